// File: rtl/calc_ctrl_pkg.sv
// Shared types and constants for the second-generation calculator controller.
package calc_ctrl_pkg;

  typedef enum logic [2:0] {
    LOCKED,
    IDLE,
    SAMPLE,
    ACCESS,
    XFER,
    ERR
  } state_t;

  localparam int MODE_BURST_BIT = 0;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit counter.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/serial_key_decoder.sv
// Serial MSB-first key+mode receiver; pulses unlock_o on the cycle the final
// bit arrives and the key field matches.
module serial_key_decoder #(
  parameter int                KEY_W     = 4,
  parameter logic [KEY_W-1:0]  KEY_VALUE = 4'b1011,
  parameter int                MODE_W    = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              input_key_i,
  input  logic              valid_cmd_i,
  input  logic              enable_i,
  output logic              unlock_o,
  output logic [MODE_W-1:0] mode_o
);

  localparam int SR_W = KEY_W + MODE_W;
  localparam int CW   = $clog2(SR_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SR_W - 1);

  // Only the first SR_W-1 bits are stored; the final bit is compared as it arrives.
  logic [SR_W-2:0] sr_q, sr_d;
  logic [SR_W-1:0] shifted;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_bit;
  logic            key_match;

  always_comb begin
    shifted   = {sr_q, input_key_i};
    last_bit  = (cnt_q == CNT_LAST);
    key_match = (shifted[SR_W-1 -: KEY_W] == KEY_VALUE);
    unlock_o  = enable_i && valid_cmd_i && last_bit && key_match;
    mode_o    = shifted[MODE_W-1:0];
    sr_d      = '0;
    cnt_d     = '0;
    // A gap in the strobe, a completed word or leaving LOCKED all restart reception.
    if (enable_i && valid_cmd_i && !last_bit) begin
      sr_d  = shifted[SR_W-2:0];
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/calc_controller_gen2.sv
// Calculator controller: serial unlock, then SAMPLE/ACCESS/XFER sequencing with
// bursts, per-beat transfer timeout and idle auto re-lock. All outputs registered.
module calc_controller_gen2
  import calc_ctrl_pkg::*;
#(
  parameter int               KEY_W        = 4,
  parameter logic [KEY_W-1:0] KEY_VALUE    = 4'b1011,
  parameter int               MODE_W       = 2,
  parameter int               BURST_LEN    = 4,
  parameter int               XFER_TIMEOUT = 16,
  parameter int               IDLE_TIMEOUT = 256,
  localparam int              BW           = clog2_min1(BURST_LEN)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              input_key_i,
  input  logic              valid_cmd_i,
  input  logic              rw_i,
  input  logic              transfer_done_i,
  output logic              active_o,
  output logic [MODE_W-1:0] mode_o,
  output logic              access_mem_o,
  output logic              rw_mem_o,
  output logic              sample_data_o,
  output logic              transfer_data_o,
  output logic              busy_o,
  output logic              error_o,
  output logic [BW-1:0]     beat_idx_o,
  output state_t            dbg_state_o
);

  localparam int IW = clog2_min1(IDLE_TIMEOUT);
  localparam int TW = clog2_min1(XFER_TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(XFER_TIMEOUT - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d, last_beat;
  logic [IW-1:0]     idle_q, idle_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              rw_q, rw_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              active_q, access_q, sample_q, xfer_q, busy_q, error_q;
  logic              key_unlock;
  logic [MODE_W-1:0] key_mode;

  serial_key_decoder #(
    .KEY_W     (KEY_W),
    .KEY_VALUE (KEY_VALUE),
    .MODE_W    (MODE_W)
  ) u_key (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .input_key_i (input_key_i),
    .valid_cmd_i (valid_cmd_i),
    .enable_i    (state_q == LOCKED),
    .unlock_o    (key_unlock),
    .mode_o      (key_mode)
  );

  assign last_beat = mode_q[MODE_BURST_BIT] ? BEAT_LAST : '0;

  // valid_cmd_i is a one-cycle strobe with no ready: it is taken only in IDLE
  // (or as a key bit in LOCKED); strobes while busy_o=1 are dropped, never queued.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    idle_d  = idle_q;
    tmr_d   = tmr_q;
    rw_d    = rw_q;
    mode_d  = mode_q;
    unique case (state_q)
      LOCKED: begin
        if (key_unlock) begin
          state_d = IDLE;
          mode_d  = key_mode;
          idle_d  = '0;
        end
      end
      IDLE: begin
        if (valid_cmd_i) begin
          state_d = SAMPLE;
          rw_d    = rw_i;
          beat_d  = '0;
          idle_d  = '0;
        end else if (idle_q == IDLE_LAST) begin
          state_d = LOCKED;
          mode_d  = '0;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      SAMPLE: state_d = ACCESS;
      ACCESS: begin
        tmr_d   = '0;
        state_d = XFER;
      end
      XFER: begin
        // Done is checked before the timer so a late acknowledge still succeeds.
        if (transfer_done_i) begin
          tmr_d = '0;
          if (beat_q != last_beat) begin
            beat_d  = beat_q + 1'b1;
            state_d = ACCESS;
          end else begin
            beat_d  = '0;
            idle_d  = '0;
            state_d = IDLE;
          end
        end else if (tmr_q == TMR_LAST) begin
          state_d = ERR;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ERR: begin
        state_d = LOCKED;
        mode_d  = '0;
        beat_d  = '0;
        tmr_d   = '0;
      end
      default: state_d = LOCKED;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= LOCKED;
      beat_q   <= '0;
      idle_q   <= '0;
      tmr_q    <= '0;
      rw_q     <= RW_READ;
      mode_q   <= '0;
      active_q <= 1'b0;
      access_q <= 1'b0;
      sample_q <= 1'b0;
      xfer_q   <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      idle_q   <= idle_d;
      tmr_q    <= tmr_d;
      rw_q     <= rw_d;
      mode_q   <= mode_d;
      active_q <= (state_d != LOCKED);
      access_q <= (state_d == ACCESS);
      sample_q <= (state_d == SAMPLE);
      xfer_q   <= (state_d == XFER);
      busy_q   <= (state_d inside {SAMPLE, ACCESS, XFER, ERR});
      error_q  <= (state_d == ERR);
    end
  end

  assign active_o        = active_q;
  assign mode_o          = mode_q;
  assign access_mem_o    = access_q;
  assign rw_mem_o        = rw_q;
  assign sample_data_o   = sample_q;
  assign transfer_data_o = xfer_q;
  assign busy_o          = busy_q;
  assign error_o         = error_q;
  assign beat_idx_o      = beat_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_calc_controller_gen2.sv
// Bench for calc_controller_gen2: vector table, multi-cycle corner sequences and
// randomized transactions checked against a transaction-level timeline model.
module tb_calc_controller_gen2;
  import calc_ctrl_pkg::*;

  localparam int BURST_LEN    = 4;
  localparam int XFER_TIMEOUT = 16;
  localparam int IDLE_TIMEOUT = 256;

  logic       clk = 1'b0;
  logic       rst, key, valid, rw, td;
  logic       active, access, rw_mem, sample, xfer, busy, error;
  logic [1:0] mode, beat;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;
  logic       sb_on;
  logic [1:0] m_mode;
  logic [2:0] exp_q[$];

  typedef struct {
    logic        valid;
    logic        key;
    logic        rw;
    logic        td;
    logic [10:0] expv;
  } vec_t;
  vec_t tbl[$];

  calc_controller_gen2 dut (
    .clk_i           (clk),
    .reset_i         (rst),
    .input_key_i     (key),
    .valid_cmd_i     (valid),
    .rw_i            (rw),
    .transfer_done_i (td),
    .active_o        (active),
    .mode_o          (mode),
    .access_mem_o    (access),
    .rw_mem_o        (rw_mem),
    .sample_data_o   (sample),
    .transfer_data_o (xfer),
    .busy_o          (busy),
    .error_o         (error),
    .beat_idx_o      (beat),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Output bundle: {active, mode[1:0], access, rw_mem, sample, xfer, busy, error, beat[1:0]}
  function automatic logic [10:0] ev(input int a, input int m, input int acc, input int rwm,
                                     input int s, input int x, input int b, input int e,
                                     input int bt);
    return {a[0], m[1:0], acc[0], rwm[0], s[0], x[0], b[0], e[0], bt[1:0]};
  endfunction

  function automatic logic [10:0] outs();
    return {active, mode, access, rw_mem, sample, xfer, busy, error, beat};
  endfunction

  // rw_mem is only meaningful with access; beat index is not checked while locked.
  task automatic chk_out(input string nm, input logic [10:0] expv);
    logic [10:0] mask;
    mask = 11'h7FF;
    if (!expv[7])  mask[6] = 1'b0;
    if (!expv[10]) mask[1:0] = 2'b00;
    chk(nm, 32'(outs() & mask), 32'(expv & mask));
  endtask

  task automatic add(input int v, input int k, input int r, input int t, input logic [10:0] e);
    vec_t vv;
    vv.valid = v[0];
    vv.key   = k[0];
    vv.rw    = r[0];
    vv.td    = t[0];
    vv.expv  = e;
    tbl.push_back(vv);
  endtask

  // ---------------- scoreboard on AccessMem pulses ----------------
  always @(negedge clk) begin
    if (sb_on && access) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_access", 1, 0);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        chk("sb_access", 32'({rw_mem, beat}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_key(input logic [1:0] m);
    logic [5:0] bits;
    bits = {4'b1011, m};
    for (int i = 5; i >= 0; i--) begin
      valid = 1'b1;
      key   = bits[i];
      tick();
      if (i > 0) chk_out("key_bit_locked", 11'h0);
      else       chk_out("key_unlock", ev(1, m, 0, 0, 0, 0, 0, 0, 0));
    end
    valid = 1'b0;
    key   = 1'b0;
  endtask

  // Expected timeline: SAMPLE, then per beat one ACCESS and d+1 XFER cycles
  // (done on the last), then IDLE with beat index 0.
  task automatic do_txn(input logic rwv, input int fix_d);
    int nb, d;
    nb = m_mode[MODE_BURST_BIT] ? BURST_LEN : 1;
    valid = 1'b1;
    rw    = rwv;
    td    = rnd1();
    tick();
    chk_out("txn_sample", ev(1, m_mode, 0, 0, 1, 0, 1, 0, 0));
    for (int b = 0; b < nb; b++) begin
      exp_q.push_back({rwv, 2'(b)});
      if (b == 0) begin
        valid = rnd1();
        td    = rnd1();
        rw    = rnd1();
        tick();
      end
      chk_out("txn_access", ev(1, m_mode, 1, rwv, 0, 0, 1, 0, b));
      valid = rnd1();
      td    = rnd1();
      rw    = rnd1();
      tick();
      d = (fix_d >= 0) ? fix_d : $urandom_range(0, XFER_TIMEOUT - 1);
      for (int j = 0; j <= d; j++) begin
        chk_out("txn_xfer", ev(1, m_mode, 0, 0, 0, 1, 1, 0, b));
        td    = (j == d);
        valid = rnd1();
        tick();
      end
    end
    valid = 1'b0;
    td    = 1'b0;
    chk_out("txn_idle", ev(1, m_mode, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic idle_gap();
    int g;
    g = $urandom_range(0, 4);
    repeat (g) begin
      valid = 1'b0;
      tick();
      chk_out("gap_idle", ev(1, m_mode, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic idle_timeout_check();
    int n;
    n = 0;
    valid = 1'b0;
    while (active && n < 400) begin
      n++;
      td = rnd1();
      tick();
    end
    td = 1'b0;
    chk("idle_timeout_len", n, IDLE_TIMEOUT);
    chk_out("idle_relock", 11'h0);
  endtask

  // ---------------- test ----------------
  initial begin
    int n;
    rst = 1'b1; key = 1'b0; valid = 1'b0; rw = 1'b0; td = 1'b0;
    sb_on = 1'b0; m_mode = 2'b00;
    tick();
    tick();
    chk("reset_outs", 32'(outs()), 0);
    chk("reset_state", 32'(dbg_state), 32'(LOCKED));
    rst = 1'b0;

    // Wrong key, aborted partial key, then key 1011 mode 00 and a write.
    add(1, 1, 0, 0, 11'h0);
    add(1, 0, 0, 1, 11'h0);
    add(1, 0, 0, 0, 11'h0);
    add(1, 1, 0, 0, 11'h0);
    add(1, 1, 0, 0, 11'h0);
    add(1, 1, 0, 0, 11'h0);
    add(1, 1, 0, 0, 11'h0);
    add(1, 0, 0, 0, 11'h0);
    add(1, 1, 0, 0, 11'h0);
    add(0, 1, 0, 0, 11'h0);
    add(1, 1, 0, 0, 11'h0);
    add(1, 0, 0, 0, 11'h0);
    add(1, 1, 0, 0, 11'h0);
    add(1, 1, 0, 0, 11'h0);
    add(1, 0, 0, 0, 11'h0);
    add(1, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 0, 1, 1, ev(1, 0, 0, 0, 1, 0, 1, 0, 0));
    add(1, 0, 0, 1, ev(1, 0, 1, 1, 0, 0, 1, 0, 0));
    add(1, 0, 0, 1, ev(1, 0, 0, 0, 0, 1, 1, 0, 0));
    add(0, 0, 0, 0, ev(1, 0, 0, 0, 0, 1, 1, 0, 0));
    add(0, 0, 0, 0, ev(1, 0, 0, 0, 0, 1, 1, 0, 0));
    add(0, 0, 0, 1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 1, ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      valid = tbl[i].valid;
      key   = tbl[i].key;
      rw    = tbl[i].rw;
      td    = tbl[i].td;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].expv);
    end
    valid = 1'b0; key = 1'b0; td = 1'b0;

    // Transfer timeout with commands during busy, then forced re-lock.
    valid = 1'b1; rw = RW_READ;
    tick();
    chk_out("to_sample", ev(1, 0, 0, 0, 1, 0, 1, 0, 0));
    valid = 1'b0;
    tick();
    chk_out("to_access", ev(1, 0, 1, 0, 0, 0, 1, 0, 0));
    tick();
    n = 0;
    while (xfer && n < 40) begin
      n++;
      valid = (n == 3 || n == 9);
      tick();
    end
    valid = 1'b0;
    chk("xfer_timeout_len", n, XFER_TIMEOUT);
    chk("err_pulse", 32'(error), 1);
    chk("err_busy", 32'(busy), 1);
    tick();
    chk_out("err_relock", 11'h0);
    tick();
    chk_out("err_stays_locked", 11'h0);

    // Round 0: burst read with immediate done, then random traffic.
    sb_on  = 1'b1;
    m_mode = 2'b01;
    send_key(m_mode);
    do_txn(RW_READ, 0);
    do_txn(RW_WRITE, XFER_TIMEOUT - 1);
    for (int t = 0; t < 4; t++) begin
      idle_gap();
      do_txn(rnd1(), -1);
    end
    idle_timeout_check();

    // Round 1: random mode; command on the idle-timeout cycle wins.
    m_mode = 2'($urandom_range(0, 3));
    send_key(m_mode);
    for (int t = 0; t < 4; t++) begin
      idle_gap();
      do_txn(rnd1(), -1);
    end
    repeat (IDLE_TIMEOUT - 1) tick();
    chk("pre_timeout_active", 32'(active), 1);
    do_txn(rnd1(), -1);
    idle_timeout_check();
    sb_on = 1'b0;

    // Round 2: reset while waiting on beat 1 of a burst.
    m_mode = 2'b11;
    send_key(m_mode);
    valid = 1'b1; rw = RW_WRITE;
    tick();
    chk_out("r2_sample", ev(1, 3, 0, 0, 1, 0, 1, 0, 0));
    valid = 1'b0;
    tick();
    chk_out("r2_access0", ev(1, 3, 1, 1, 0, 0, 1, 0, 0));
    tick();
    chk_out("r2_xfer0", ev(1, 3, 0, 0, 0, 1, 1, 0, 0));
    td = 1'b1;
    tick();
    td = 1'b0;
    chk_out("r2_access1", ev(1, 3, 1, 1, 0, 0, 1, 0, 1));
    tick();
    chk_out("r2_xfer1", ev(1, 3, 0, 0, 0, 1, 1, 0, 1));
    rst = 1'b1;
    tick();
    chk("reset_mid_xfer", 32'(outs()), 0);
    chk("reset_mid_state", 32'(dbg_state), 32'(LOCKED));
    rst = 1'b0;
    m_mode = 2'b10;
    send_key(m_mode);

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
